// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Small FIFO skid buffer placed between two pipeline stages. It holds up to
// DEPTH stage payloads and hands them downstream in arrival order. A flush
// (branch, jump or trap redirect) empties the buffer and drops the payload
// offered in the same cycle.
//
// Parameters
//   WIDTH  packed stage-payload width in bits
//   DEPTH  number of entries; a power of two from 2 to 16
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset (clears pointers and count)
//   flush      discard all held and incoming entries at the next edge
//   in_valid   upstream offers in_data
//   in_ready   buffer accepts a payload this cycle
//   in_data    upstream payload
//   out_valid  head entry available
//   out_ready  downstream consumes the head
//   out_data   head payload (don't-care while empty)
//   count      number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // Handshake outputs depend only on occupancy and the opposite side's
    // ready; flush is deliberately kept out so it never forms a comb path
    // into either handshake.
    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full || out_ready;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // NOTE: the payload array has no reset; only pointers and count define
    // which entries are live, so clearing storage would buy nothing.
    // When full and popped in the same cycle, wr_ptr equals rd_ptr: the new
    // entry overwrites the departing head, which is safe because the read of
    // the old head and the write both resolve at the same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // Pointers are power-of-two wide, so the increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Directed bench for pipe_stage_buf. Three instances (DEPTH 2, 4 and 8, all
// WIDTH 8) share clock and reset; each scenario drives one instance while the
// others idle. Inputs change 1 time unit after the rising edge and outputs
// are sampled 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    logic       resetn;

    logic       flush     [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] in_data   [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] out_data  [3];
    logic [4:0] cnt       [3];

    logic [1:0] c2;
    logic [2:0] c4;
    logic [3:0] c8;

    assign cnt[0] = 5'(c2);
    assign cnt[1] = 5'(c4);
    assign cnt[2] = 5'(c8);

    int checks = 0;
    int errors = 0;

    localparam int I2 = 0;
    localparam int I4 = 1;
    localparam int I8 = 2;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u2 (
        .clk(clk), .resetn(resetn), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .count(c2)
    );

    pipe_stage_buf #(.WIDTH(8), .DEPTH(4)) u4 (
        .clk(clk), .resetn(resetn), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .count(c4)
    );

    pipe_stage_buf #(.WIDTH(8), .DEPTH(8)) u8 (
        .clk(clk), .resetn(resetn), .flush(flush[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .count(c8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] d,
                         input logic r, input logic f);
        in_valid[i]  = v;
        in_data[i]   = d;
        out_ready[i] = r;
        flush[i]     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_seq[4];
    logic       rv;
    logic       rr;
    logic [7:0] rd;
    logic       mpush;
    logic       mpop;
    logic [2:0] wr_old;
    logic [2:0] rd_old;
    int         wr_wraps;
    int         rd_wraps;

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset held: state cleared before and across clock edges.
        #1;
        check("rst_cnt_pre", cnt[I2], 0);
        check("rst_ovalid_pre", out_valid[I2], 0);
        check("rst_iready_pre", in_ready[I2], 1);
        in_valid[I4] = 1'b1;
        tick();
        tick();
        check("rst_cnt_edges", cnt[I4], 0);
        check("rst_ovalid_edges", out_valid[I4], 0);
        check("rst_iready_edges", in_ready[I8], 1);
        in_valid[I4] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;

        // DEPTH=2: push A1, A2 with out_ready=0, then drain.
        drive(I2, 1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        check("s1_cnt1", cnt[I2], 1);
        check("s1_ovalid1", out_valid[I2], 1);
        drive(I2, 1'b1, 8'hA2, 1'b0, 1'b0);
        tick();
        drive(I2, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("s1_cnt2", cnt[I2], 2);
        check("s1_iready_full", in_ready[I2], 0);
        check("s1_head", out_data[I2], 8'hA1);
        drive(I2, 1'b0, 8'h00, 1'b1, 1'b0);
        settle();
        check("s1_iready_full_pop", in_ready[I2], 1);
        check("s1_out0", out_data[I2], 8'hA1);
        tick();
        check("s1_out1", out_data[I2], 8'hA2);
        check("s1_cnt_after1", cnt[I2], 1);
        tick();
        check("s1_cnt_empty", cnt[I2], 0);
        check("s1_ovalid_empty", out_valid[I2], 0);
        drive(I2, 1'b0, 8'h00, 1'b0, 1'b0);

        // DEPTH=4: fill 1..4, simultaneous push 5 / pop, drain 2,3,4,5.
        for (int k = 1; k <= 4; k++) begin
            drive(I4, 1'b1, 8'(k), 1'b0, 1'b0);
            tick();
        end
        drive(I4, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("s2_full_cnt", cnt[I4], 4);
        check("s2_full_iready", in_ready[I4], 0);
        drive(I4, 1'b1, 8'h05, 1'b1, 1'b0);
        settle();
        check("s2_pp_iready", in_ready[I4], 1);
        check("s2_pp_head", out_data[I4], 8'h01);
        tick();
        check("s2_pp_cnt", cnt[I4], 4);
        drive(I4, 1'b0, 8'h00, 1'b1, 1'b0);
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h05;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("s2_drain%0d", k), out_data[I4], exp_seq[k]);
            tick();
        end
        check("s2_drain_cnt", cnt[I4], 0);
        drive(I4, 1'b0, 8'h00, 1'b0, 1'b0);

        // DEPTH=4: count=3, flush with 0x77 offered.
        for (int k = 0; k < 3; k++) begin
            drive(I4, 1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
            tick();
        end
        drive(I4, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("s3_cnt3", cnt[I4], 3);
        drive(I4, 1'b1, 8'h77, 1'b1, 1'b1);
        tick();
        drive(I4, 1'b0, 8'h00, 1'b1, 1'b0);
        settle();
        check("s3_flush_cnt", cnt[I4], 0);
        check("s3_flush_ovalid", out_valid[I4], 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("s3_no77_%0d", k), out_valid[I4], 0);
        end
        drive(I4, 1'b1, 8'h33, 1'b0, 1'b0);
        tick();
        drive(I4, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("s3_post_data", out_data[I4], 8'h33);
        check("s3_post_cnt", cnt[I4], 1);

        // DEPTH=8: 40 random cycles against a reference queue.
        q.delete();
        wr_wraps = 0;
        rd_wraps = 0;
        for (int n = 0; n < 40; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            rd = 8'($urandom_range(0, 255));
            drive(I8, rv, rd, rr, 1'b0);
            settle();
            check("s4_cnt", cnt[I8], q.size());
            check("s4_cnt_le8", (cnt[I8] <= 5'd8), 1);
            check("s4_ovalid", out_valid[I8], (q.size() != 0));
            check("s4_iready", in_ready[I8], (q.size() < 8) || rr);
            if (q.size() != 0) check("s4_head", out_data[I8], q[0]);
            mpush = rv && ((q.size() < 8) || rr);
            mpop  = rr && (q.size() != 0);
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back(rd);
            wr_old = u8.wr_ptr;
            rd_old = u8.rd_ptr;
            tick();
            if (wr_old == 3'd7 && u8.wr_ptr == 3'd0) wr_wraps++;
            if (rd_old == 3'd7 && u8.rd_ptr == 3'd0) rd_wraps++;
        end
        drive(I8, 1'b0, 8'h00, 1'b1, 1'b0);
        while (q.size() != 0) begin
            settle();
            check("s4_drain", out_data[I8], q[0]);
            void'(q.pop_front());
            rd_old = u8.rd_ptr;
            tick();
            if (rd_old == 3'd7 && u8.rd_ptr == 3'd0) rd_wraps++;
        end
        check("s4_end_cnt", cnt[I8], 0);
        check("s4_wr_wrap2", (wr_wraps >= 2), 1);
        check("s4_rd_wrap2", (rd_wraps >= 2), 1);
        drive(I8, 1'b0, 8'h00, 1'b0, 1'b0);

        // DEPTH=2: async reset between edges while count=2.
        drive(I2, 1'b1, 8'h21, 1'b0, 1'b0);
        tick();
        drive(I2, 1'b1, 8'h22, 1'b0, 1'b0);
        tick();
        drive(I2, 1'b0, 8'h00, 1'b1, 1'b0);
        settle();
        check("s5_cnt2", cnt[I2], 2);
        #2;
        resetn = 1'b0;
        #1;
        check("s5_async_cnt", cnt[I2], 0);
        check("s5_async_ovalid", out_valid[I2], 0);
        check("s5_async_iready", in_ready[I2], 1);
        #2;
        resetn = 1'b1;
        tick();
        check("s5_no_pop_cnt", cnt[I2], 0);
        check("s5_no_pop_ptr", u2.rd_ptr, 0);
        drive(I2, 1'b0, 8'h00, 1'b0, 1'b0);

        // DEPTH=2: push 0x5 into empty buffer with out_ready held high.
        drive(I2, 1'b1, 8'h05, 1'b1, 1'b0);
        settle();
        check("s6_ovalid_push", out_valid[I2], 0);
        check("s6_iready_push", in_ready[I2], 1);
        tick();
        drive(I2, 1'b0, 8'h00, 1'b1, 1'b0);
        settle();
        check("s6_ovalid_next", out_valid[I2], 1);
        check("s6_data_next", out_data[I2], 8'h05);
        check("s6_cnt_next", cnt[I2], 1);
        tick();
        check("s6_cnt_final", cnt[I2], 0);
        check("s6_ovalid_final", out_valid[I2], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the packed stage-payload width in bits (sized by the instantiating stage to its stage struct).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of payload entries; legal values are powers of two from 2 to 16.
REQ-003 Reset is asynchronous and active-low; the block SHALL use one clock.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit: discard all held and incoming entries (branch, jump or trap redirect).
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream stage offers a payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: buffer accepts a payload this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: head entry available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: head payload.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-014 A push SHALL occur on a rising edge when in_valid=1, in_ready=1 and flush=0.
REQ-015 A pop SHALL occur on a rising edge when out_valid=1, out_ready=1 and flush=0.
REQ-016 in_ready SHALL equal (count<DEPTH) OR (count==DEPTH AND out_ready=1), so a full buffer accepts when simultaneously popped.
REQ-017 in_ready SHALL NOT depend on in_valid, and out_valid SHALL NOT depend on out_ready.
REQ-018 out_valid SHALL equal (count!=0).
REQ-019 out_data SHALL present the oldest entry; when count=0 its value is don't-care.
REQ-020 Latency SHALL be exactly one cycle from push to out_valid, with no combinational in-to-out bypass.
REQ-021 Entries SHALL leave in push order (FIFO).
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-023 count SHALL change as follows: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-024 Push and pop SHALL be allowed in the same cycle when count=0; the pop does not occur because out_valid=0, so count becomes 1.
REQ-025 Push and pop SHALL be allowed in the same cycle when count=DEPTH; count stays at DEPTH and the new entry is appended behind the remaining entries.
REQ-026 When flush=1 at a rising edge, count and both pointers SHALL clear to 0, any in_valid payload SHALL be dropped, and no pop SHALL be counted.
REQ-027 flush SHALL NOT gate in_ready or out_valid combinationally.
REQ-028 Stages therefore SHALL ignore the handshake in a flush cycle.
REQ-029 Storage SHALL NOT require reset; only the pointers and count are reset.
REQ-030 Pushes when not ready, and pops when empty, SHALL have no effect on any state.

Reset
REQ-031 While resetn=0, count SHALL be 0, both pointers SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1, independent of clk.
REQ-032 Assertion of resetn in the middle of operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-033 The first push SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-034 The bench SHALL cover this scenario: DEPTH=2, reset, then push 0xA1, 0xA2 with out_ready=0 -> count=2, in_ready=0, out_data=0xA1; assert out_ready -> outputs 0xA1 then 0xA2, then count=0.
REQ-035 The bench SHALL cover this scenario: full at DEPTH=4 with entries 1,2,3,4, then in_valid=1 with data 5 and out_ready=1 for one cycle -> 1 is popped, 5 is pushed, count stays 4, and the drain order is 2,3,4,5.
REQ-036 The bench SHALL cover this scenario: count=3, then flush=1 with in_valid=1 and data 0x77 -> next cycle count=0, out_valid=0, and 0x77 never appears at the output.
REQ-037 The bench SHALL cover this scenario: 40 random push/pop cycles at DEPTH=8 -> the output order matches a reference queue, count never exceeds 8, and the pointers wrap at least twice.
REQ-038 The bench SHALL cover this scenario: resetn pulsed low between clock edges while count=2 -> out_valid=0 and count=0 before the next edge, with no spurious pop.
REQ-039 The bench SHALL cover this scenario: empty buffer, push 0x5 with out_ready=1 held -> out_valid=0 in the push cycle and 1 in the next cycle, then 0x5 is consumed and count returns to 0.
